merge_feed_ctrl: RTL
====================

# merge_feed_ctrl

Sequencer between the two per-way record FIFOs and MERGE_NETWORK in the hardware merge sorter. Each transaction merges one sorted run of RUN_BLOCKS blocks per way. The block repeatedly compares the head-block keys, dequeues the smaller way, and presents that block to the merge network. When one way's run is exhausted it drains the other way without comparing. It signals completion when 2·RUN_BLOCKS blocks have been issued.

## Interface
Parameters:
- E_LOG, 2: log2 of records per block (1..5).
- DATW, 64: record width in bits.
- KEYW, 32: key width; the key is record bits [KEYW-1:0].
- RUNW, 16: width of the run-length counters.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin a transaction; sampled only in IDLE.
- RUN_BLOCKS  in  RUNW  blocks per way for this run; sampled with START.
- A_DOT  in  DATW<<E_LOG  head block of way A.
- A_EMP  in  1  way-A FIFO empty.
- A_DEQ  out  1  dequeue way A; combinational.
- B_DOT  in  DATW<<E_LOG  head block of way B.
- B_EMP  in  1  way-B FIFO empty.
- B_DEQ  out  1  dequeue way B; combinational.
- STALL  in  1  downstream cannot accept; blocks any dequeue this cycle.
- SEL_DOT  out  DATW<<E_LOG  selected block to the merge network; registered.
- SEL_DOTEN  out  1  SEL_DOT valid; registered.
- BUSY  out  1  high in MERGE, DRAIN_A and DRAIN_B.
- DONE  out  1  one-cycle pulse at the end of a run; registered.

## Operation
- States: IDLE, MERGE, DRAIN_A, DRAIN_B, FIN.
- IDLE + START:
  - RUN_BLOCKS==0 -> FIN; no dequeues occur.
  - Otherwise load remA=remB=RUN_BLOCKS and go to MERGE.
- MERGE:
  - Dequeue is allowed only when !A_EMP && !B_EMP && !STALL.
  - Compare unsigned A_DOT[KEYW-1:0] < B_DOT[KEYW-1:0]. True -> A_DEQ and remA-1. False (ties included) -> B_DEQ and remB-1.
  - Next state is evaluated on the post-decrement counters: remA==0 -> DRAIN_B; remB==0 -> DRAIN_A; else stay in MERGE.
- DRAIN_A: A_DEQ = !A_EMP && !STALL; remA-1 per dequeue. B_EMP and B_DOT are ignored. remA reaches 0 -> FIN.
- DRAIN_B: mirror of DRAIN_A.
- FIN: DONE=1 for exactly one cycle, then -> IDLE.
- A_DEQ and B_DEQ are never high in the same cycle. Both are 0 in IDLE, FIN, and during RST.
- START is ignored outside IDLE.
- Counters never underflow. No dequeue is issued for a way whose remaining count is 0.

## Timing
- Reset values: state IDLE, remA=remB=0, SEL_DOT=0, SEL_DOTEN=0, BUSY=0, DONE=0.
- Output latency is 1 cycle. A dequeue in cycle t gives SEL_DOTEN=1 in t+1, with SEL_DOT equal to the dequeued block's value at t.
- Without a dequeue, SEL_DOTEN=0 in the next cycle and SEL_DOT holds its previous value.
- Throughput is 1 block/cycle when the FIFOs are non-empty and STALL=0.
- STALL=1 in cycle t: no dequeue in t, SEL_DOTEN=0 in t+1, and counters and state are unchanged.
- START in IDLE at cycle t: BUSY=1 from t+1. The first dequeue can occur in t+1.
- DONE timing:
  - The last dequeue in cycle t gives its SEL_DOTEN in t+1, concurrent with the FIN state; DONE=1 in t+2 (registered from FIN).
  - The next START is accepted in t+2 or later.
- RUN_BLOCKS==0: START at t -> FIN at t+1 -> DONE at t+2.
- RST asserted mid-run: the next edge forces every reset value; in-flight counts are discarded. FIFO contents are not the controller's concern.

## Test plan
- Interleaved streams (E_LOG=2, RUN_BLOCKS=4): A head keys 1,9,17,25; B head keys 5,13,21,29; FIFOs pre-filled; START.
  - Required: strictly alternating dequeue order A,B,A,B,A,B,A,B.
  - Required: SEL_DOTEN high for 8 consecutive cycles starting 1 cycle after the first deq.
  - Required: DONE 1 cycle after the last SEL_DOTEN.
- Early exhaustion: A keys 1,2,3; B keys 10,11,12; RUN_BLOCKS=3.
  - Required: A,A,A then DRAIN_B yields B,B,B.
  - Required: B_DEQ in DRAIN_B does not depend on A_EMP (hold A_EMP=1).
- Tie and empty: A key 7 = B key 7 -> B dequeued first. Hold B_EMP=1 for 3 cycles in MERGE -> no deq and SEL_DOTEN=0 for those cycles; counts unchanged.
- STALL: toggle STALL 1,0,1,0 during MERGE (RUN_BLOCKS=2).
  - Required: dequeues only in STALL=0 cycles.
  - Required: 4 total SEL_DOTEN pulses, then DONE.
- RUN_BLOCKS=0 and START-while-busy:
  - RUN_BLOCKS=0: DONE exactly 2 cycles after START with no deqs.
  - START re-pulsed mid-run is ignored; the issued block count stays 2·RUN_BLOCKS.
- Reset mid-run: assert RST after 3 of 8 blocks.
  - Required: BUSY=0, SEL_DOTEN=0, DONE=0, no deqs.
  - Required: a fresh START with RUN_BLOCKS=2 completes 4 blocks normally.

Source files
------------

// File: rtl/merge_feed_ctrl.sv
// merge_feed_ctrl: sequences two sorted per-way runs into MERGE_NETWORK.
// Takes the smaller head key each cycle, then drains the surviving way.
module merge_feed_ctrl #(
  parameter int E_LOG = 2,
  parameter int DATW  = 64,
  parameter int KEYW  = 32,
  parameter int RUNW  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [RUNW-1:0]          RUN_BLOCKS,
  input  logic [(DATW<<E_LOG)-1:0] A_DOT,
  input  logic                     A_EMP,
  output logic                     A_DEQ,
  input  logic [(DATW<<E_LOG)-1:0] B_DOT,
  input  logic                     B_EMP,
  output logic                     B_DEQ,
  input  logic                     STALL,
  output logic [(DATW<<E_LOG)-1:0] SEL_DOT,
  output logic                     SEL_DOTEN,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int BW = DATW << E_LOG;
  localparam logic [RUNW-1:0] ONE = RUNW'(1);

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    DRAIN_A,
    DRAIN_B,
    FIN
  } state_t;

  state_t          state;
  logic [RUNW-1:0] rem_a;
  logic [RUNW-1:0] rem_b;
  logic [BW-1:0]   sel_dot;
  logic            sel_en;
  logic            done;
  logic            a_lt;
  logic            a_go;
  logic            b_go;

  // ties go to B, so A wins only on a strictly smaller key
  assign a_lt = A_DOT[KEYW-1:0] < B_DOT[KEYW-1:0];

  // Dequeue decode: at most one way, never past its run length
  always_comb begin
    a_go = 1'b0;
    b_go = 1'b0;
    if (!RST && !STALL) begin
      case (state)
        MERGE: begin
          if (!A_EMP && !B_EMP) begin
            a_go = a_lt && (rem_a != '0);
            b_go = !a_lt && (rem_b != '0);
          end
        end
        DRAIN_A: a_go = !A_EMP && (rem_a != '0);
        DRAIN_B: b_go = !B_EMP && (rem_b != '0);
        default: begin
          a_go = 1'b0;
          b_go = 1'b0;
        end
      endcase
    end
  end

  assign A_DEQ     = a_go;
  assign B_DEQ     = b_go;
  assign SEL_DOT   = sel_dot;
  assign SEL_DOTEN = sel_en;
  assign DONE      = done;
  assign BUSY      = (state == MERGE) ||
                     (state == DRAIN_A) ||
                     (state == DRAIN_B);

  // FSM, run counters and the registered merge-network feed
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      rem_a   <= '0;
      rem_b   <= '0;
      sel_dot <= '0;
      sel_en  <= 1'b0;
      done    <= 1'b0;
    end else begin
      sel_en <= a_go || b_go;
      if (a_go) begin
        sel_dot <= A_DOT;
      end else if (b_go) begin
        sel_dot <= B_DOT;
      end
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (START) begin
            if (RUN_BLOCKS == '0) begin
              state <= FIN;
            end else begin
              rem_a <= RUN_BLOCKS;
              rem_b <= RUN_BLOCKS;
              state <= MERGE;
            end
          end
        end
        MERGE: begin
          if (a_go) begin
            rem_a <= rem_a - ONE;
            if (rem_a == ONE) state <= DRAIN_B;
          end
          if (b_go) begin
            rem_b <= rem_b - ONE;
            if (rem_b == ONE) state <= DRAIN_A;
          end
        end
        DRAIN_A: begin
          if (a_go) begin
            rem_a <= rem_a - ONE;
            if (rem_a == ONE) state <= FIN;
          end else if (rem_a == '0) begin
            state <= FIN;
          end
        end
        DRAIN_B: begin
          if (b_go) begin
            rem_b <= rem_b - ONE;
            if (rem_b == ONE) state <= FIN;
          end else if (rem_b == '0) begin
            state <= FIN;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
